run_sequencer: RTL and testbench
================================

// Module: run_sequencer
// PURPOSE
// Host-side run controller sitting directly upstream of the processor core.
// Owns the core's start handshake: resets the core (init), pulses req, then waits for ack.
// Measures run latency in cycles, aborts hung runs on timeout and reports a per-run result.
// Testbench and FPGA wrapper issue runs through a simple valid/ready interface.
// PARAMETERS
// RESET_CYCLES  2     cycles core_init is held high before each run (>=1)
// REQ_CYCLES    1     cycles core_req is held high (>=1)
// CW            16    width of cycle counter / timeout compare
// TIMEOUT       4000  cycles in REQ+RUN before abort (1..2^CW-2)
// PORTS
// clk          in   1   clock, all state on rising edge
// init         in   1   synchronous active-high reset of this block
// run_valid    in   1   host requests a run
// run_ready    out  1   high only in IDLE; run accepted when run_valid&&run_ready
// busy         out  1   high in every state except IDLE
// done         out  1   one-cycle pulse; run finished (ack or timeout)
// timed_out    out  1   result flag; valid from done, held until next accept
// cycle_count  out  CW  cycles from REQ entry to ack; held until next accept
// runs_done    out  8   completed runs (ack only), wraps 255->0
// core_init    out  1   to core init
// core_req     out  1   to core req
// core_ack     in   1   from core ack (Done flag)
// BEHAVIOUR
// Reset (init=1): state=IDLE; run_ready=1 after reset; core_init=1 during reset cycle(s), 0 after.
//   core_req=0, busy=0, done=0, timed_out=0, cycle_count=0, runs_done=0.
// All outputs registered, except run_ready/busy decoded from state.
// FSM states:
//   IDLE->RST on accept; clears timed_out and cycle_count.
//   RST: core_init=1 for RESET_CYCLES cycles, then REQ.
//   REQ: core_req=1 for REQ_CYCLES cycles, then RUN.
//   RUN: wait for core_ack.
//   ABRT: core_init=1 for exactly 1 cycle, then FIN.
//   FIN: done=1 for 1 cycle, then IDLE.
// Counting: cycle_count=0 on REQ entry; +1 each cycle in REQ and RUN while core_ack=0.
//   Saturates at 2^CW-1.
// Ack: core_ack sampled high in REQ or RUN -> FIN; count frozen, runs_done+1.
//   The same-cycle count increment is suppressed.
//   core_ack ignored in IDLE, RST, ABRT, FIN (stale ack from a prior run never completes a run).
// Timeout: core_ack=0 and cycle_count==TIMEOUT in REQ/RUN -> ABRT; timed_out=1; runs_done unchanged.
//   Ack and timeout in the same cycle: ack wins.
// Latency: accept at edge N -> core_init high N+1..N+RESET_CYCLES -> core_req from N+RESET_CYCLES+1.
// Ack sampled at edge M -> done high during cycle M+1 -> run_ready high at M+2.
// run_valid while busy: ignored, no queuing.
// init mid-run: immediate return to reset values; core_init=1 that cycle; no done pulse.
// STRUCTURE
// Definitions package: seq_state_e enum {IDLE,RST,REQ,RUN,ABRT,FIN}.
// A local phase counter is sized $clog2(max(RESET_CYCLES,REQ_CYCLES))+1.
// Sub-module sat_counter #(W) (clk,init,clr,en,q,at_max): used for cycle_count.
// TESTING
// 1 Core model acks 37 cycles after req rises, RESET_CYCLES=2
//   -> core_init 2 cycles, req 1 cycle, done once, cycle_count=37, timed_out=0, runs_done=1.
// 2 Core never acks, TIMEOUT=20
//   -> ABRT after cycle_count=20, core_init 1-cycle pulse, done, timed_out=1, runs_done=0.
// 3 run_valid held high through 3 back-to-back runs
//   -> exactly 3 accepts, each gated by run_ready; runs_done=3; no accept while busy.
// 4 core_ack stuck high before accept
//   -> ignored in RST; run completes in REQ on first cycle with cycle_count=0.
// 5 init pulsed during RUN at cycle 10
//   -> all outputs at reset values next cycle, no done, next run behaves as test 1.
// 6 Ack and timeout coincide (ack exactly at count TIMEOUT); runs_done wraps 255->0 after 256 runs
//   -> timed_out=0, count=TIMEOUT.

Source files
------------

// File: rtl/run_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : run_sequencer_pkg
//  Purpose : Shared definitions for the run sequencer: FSM state encoding,
//            the width of the completed-run counter and a small elaboration
//            helper used to size the local phase counter.
//  Revision: 1.0 - initial release
// ============================================================================
package run_sequencer_pkg;

  // Sequencer states. The explicit encoding keeps state values stable
  // across tools.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    REQ  = 3'd2,
    RUN  = 3'd3,
    ABRT = 3'd4,
    FIN  = 3'd5
  } seq_state_e;

  // Width of the completed-run counter (wraps 255 -> 0).
  localparam int unsigned RUNS_W = 8;

  // Larger of two unsigned values, evaluated at elaboration time.
  function automatic int unsigned max_u(input int unsigned a,
                                        input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage : run_sequencer_pkg
`default_nettype wire

// File: rtl/run_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module  : sat_counter
//  Purpose : W-bit up-counter with synchronous clear that sticks at its
//            all-ones value instead of wrapping.
//  Ports   : clk    in  1  clock, state on rising edge
//            init   in  1  synchronous active-high reset (count -> 0)
//            clr    in  1  synchronous clear (count -> 0), beats en
//            en     in  1  count enable
//            q      out W  current count
//            at_max out 1  count is at 2^W-1
//  Revision: 1.0 - initial release
// ============================================================================
module sat_counter
  import run_sequencer_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         init,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         at_max
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max = &cnt_q;
  assign q      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_max) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : run_sequencer
//  Purpose : Host-side run controller in front of the processor core. On each
//            accepted run it holds the core in init, pulses req, waits for
//            ack, measures the latency, aborts hung runs on timeout and
//            reports a per-run result.
//  Ports   : clk          in  1   clock, state on rising edge
//            init         in  1   synchronous active-high reset
//            run_valid    in  1   host requests a run
//            run_ready    out 1   high only in IDLE
//            busy         out 1   high in every state except IDLE
//            done         out 1   one-cycle pulse when a run finishes
//            timed_out    out 1   last run was aborted (held until accept)
//            cycle_count  out CW  cycles from req to ack (held until accept)
//            runs_done    out 8   runs completed by ack, wrapping
//            core_init    out 1   core init
//            core_req     out 1   core start request
//            core_ack     in  1   core done flag
//  Revision: 1.0 - initial release
// ============================================================================
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned REQ_CYCLES   = 1,
  parameter int unsigned CW           = 16,
  parameter int unsigned TIMEOUT      = 4000
) (
  input  logic              clk,
  input  logic              init,
  input  logic              run_valid,
  output logic              run_ready,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [CW-1:0]     cycle_count,
  output logic [RUNS_W-1:0] runs_done,
  output logic              core_init,
  output logic              core_req,
  input  logic              core_ack
);

  // Phase counter covers the longer of the init and req hold windows.
  localparam int unsigned    PW          = $clog2(max_u(RESET_CYCLES, REQ_CYCLES)) + 1;
  localparam logic [PW-1:0]  c_rst_last  = PW'(RESET_CYCLES - 1);
  localparam logic [PW-1:0]  c_req_last  = PW'(REQ_CYCLES - 1);
  localparam logic [CW-1:0]  c_timeout   = CW'(TIMEOUT);

  seq_state_e        state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              core_init_q, core_init_d;
  logic              core_req_q, core_req_d;
  logic              done_q, done_d;
  logic              timed_out_q, timed_out_d;
  logic [RUNS_W-1:0] runs_done_q, runs_done_d;

  logic              w_accept;
  logic              w_in_wait;
  logic              w_ack_hit;
  logic              w_timeout_hit;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_cnt_at_max;
  logic [CW-1:0]     w_count;

  assign run_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign w_accept  = run_valid && run_ready;

  // core_ack only matters while the core is actually running a request;
  // a stale ack held over from a previous run is ignored elsewhere.
  assign w_in_wait     = (state_q == REQ) || (state_q == RUN);
  assign w_ack_hit     = w_in_wait && core_ack;
  // Ack has priority: timeout only fires when ack is low on the same edge.
  assign w_timeout_hit = w_in_wait && !core_ack && (w_count == c_timeout);

  // Count is zeroed on accept and again on entry to REQ; it freezes on the
  // edge that samples ack or detects the timeout.
  assign w_cnt_clr = w_accept || ((state_q == RST) && (phase_q == c_rst_last));
  assign w_cnt_en  = w_in_wait && !core_ack && !w_timeout_hit && !w_cnt_at_max;

  sat_counter #(
    .W (CW)
  ) u_cycle_cnt (
    .clk    (clk),
    .init   (init),
    .clr    (w_cnt_clr),
    .en     (w_cnt_en),
    .q      (w_count),
    .at_max (w_cnt_at_max)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    core_init_d = 1'b0;
    core_req_d  = 1'b0;
    done_d      = 1'b0;
    timed_out_d = timed_out_q;
    runs_done_d = runs_done_q;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d     = RST;
          phase_d     = '0;
          core_init_d = 1'b1;
          timed_out_d = 1'b0;
        end
      end

      RST: begin
        if (phase_q == c_rst_last) begin
          state_d    = REQ;
          phase_d    = '0;
          core_req_d = 1'b1;
        end else begin
          phase_d     = phase_q + PW'(1);
          core_init_d = 1'b1;
        end
      end

      REQ, RUN: begin
        if (w_ack_hit) begin
          state_d     = FIN;
          done_d      = 1'b1;
          runs_done_d = runs_done_q + RUNS_W'(1);
        end else if (w_timeout_hit) begin
          state_d     = ABRT;
          core_init_d = 1'b1;
          timed_out_d = 1'b1;
        end else if (state_q == REQ) begin
          if (phase_q == c_req_last) begin
            state_d = RUN;
          end else begin
            phase_d    = phase_q + PW'(1);
            core_req_d = 1'b1;
          end
        end
      end

      ABRT: begin
        state_d = FIN;
        done_d  = 1'b1;
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      core_init_q <= 1'b0;
      core_req_q  <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      runs_done_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      core_init_q <= core_init_d;
      core_req_q  <= core_req_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      runs_done_q <= runs_done_d;
    end
  end

  // The core is held in init for as long as this block itself is in reset,
  // so it starts from a clean state together with the sequencer.
  assign core_init   = init | core_init_q;
  assign core_req    = core_req_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = w_count;
  assign runs_done   = runs_done_q;

endmodule : run_sequencer
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_run_sequencer
//  Purpose : Self-checking bench for run_sequencer (TIMEOUT = 40).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_run_sequencer;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        init;
  logic        run_valid;
  logic        core_ack;
  logic        run_ready;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic [15:0] cycle_count;
  logic [7:0]  runs_done;
  logic        core_init;
  logic        core_req;

  always #5 clk = ~clk;

  run_sequencer #(
    .RESET_CYCLES (2),
    .REQ_CYCLES   (1),
    .CW           (16),
    .TIMEOUT      (TO)
  ) u_dut (
    .clk         (clk),
    .init        (init),
    .run_valid   (run_valid),
    .run_ready   (run_ready),
    .busy        (busy),
    .done        (done),
    .timed_out   (timed_out),
    .cycle_count (cycle_count),
    .runs_done   (runs_done),
    .core_init   (core_init),
    .core_req    (core_req),
    .core_ack    (core_ack)
  );

  int       n_checks = 0;
  int       n_fail   = 0;
  bit [7:0] exp_runs = 8'd0;

  typedef struct {
    int delay;      // cycles after req rises before ack is driven; -1 = never
    bit pre_ack;    // ack already high before the run is accepted
    int exp_count;
    bit exp_to;
    int exp_init;   // total core_init high cycles in the run
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one run from IDLE (called on a negedge) and check its result.
  task automatic do_run(input string tag, input int delay, input bit pre_ack,
                        input int exp_count, input bit exp_to, input int exp_init);
    int n_init = 0;
    int n_req  = 0;
    int k      = 0;
    bit req_seen = 1'b0;
    bit fin      = 1'b0;
    int cnt_at_done = 0;
    int to_at_done  = 0;
    int rdy_at_done = 0;
    chk({tag, "_ready_before"}, int'(run_ready), 1);
    core_ack  = pre_ack;
    run_valid = 1'b1;
    @(negedge clk);
    run_valid = 1'b0;
    chk({tag, "_busy_after_accept"}, int'(busy), 1);
    chk({tag, "_to_cleared"}, int'(timed_out), 0);
    chk({tag, "_cnt_cleared"}, int'(cycle_count), 0);
    for (int i = 0; i < 300 && !fin; i++) begin
      if (core_init) n_init++;
      if (core_req)  n_req++;
      if (done) begin
        fin         = 1'b1;
        cnt_at_done = int'(cycle_count);
        to_at_done  = int'(timed_out);
        rdy_at_done = int'(run_ready);
      end
      if (req_seen) k++;
      else if (core_req) begin
        req_seen = 1'b1;
        k        = 0;
      end
      if (!fin && req_seen && delay >= 0 && k == delay) core_ack = 1'b1;
      if (!fin) @(negedge clk);
    end
    core_ack = 1'b0;
    chk({tag, "_done_seen"}, int'(fin), 1);
    if (!exp_to) exp_runs = exp_runs + 8'd1;
    chk({tag, "_init_cycles"}, n_init, exp_init);
    chk({tag, "_req_cycles"}, n_req, 1);
    chk({tag, "_count"}, cnt_at_done, exp_count);
    chk({tag, "_timed_out"}, to_at_done, int'(exp_to));
    chk({tag, "_ready_in_fin"}, rdy_at_done, 0);
    chk({tag, "_runs_done"}, int'(runs_done), int'(exp_runs));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, int'(done), 0);
    chk({tag, "_ready_after"}, int'(run_ready), 1);
    chk({tag, "_count_held"}, int'(cycle_count), exp_count);
  endtask

  // Hold run_valid (with ack stuck high) for ncyc negedges starting in IDLE.
  task automatic burst(input int ncyc, output int acc, output int dn);
    acc = 0;
    dn  = 0;
    core_ack  = 1'b1;
    run_valid = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (run_ready) acc++;
      if (done) dn++;
      @(negedge clk);
    end
    run_valid = 1'b0;
    core_ack  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int dn;
    int w;

    vecs[0] = '{delay: 37, pre_ack: 1'b0, exp_count: 37, exp_to: 1'b0, exp_init: 2};
    vecs[1] = '{delay: -1, pre_ack: 1'b0, exp_count: TO, exp_to: 1'b1, exp_init: 3};
    vecs[2] = '{delay: 0,  pre_ack: 1'b1, exp_count: 0,  exp_to: 1'b0, exp_init: 2};
    vecs[3] = '{delay: 0,  pre_ack: 1'b0, exp_count: 0,  exp_to: 1'b0, exp_init: 2};
    vecs[4] = '{delay: TO, pre_ack: 1'b0, exp_count: TO, exp_to: 1'b0, exp_init: 2};
    vecs[5] = '{delay: TO + 1, pre_ack: 1'b0, exp_count: TO, exp_to: 1'b1, exp_init: 3};
    vecs[6] = '{delay: 1,  pre_ack: 1'b0, exp_count: 1,  exp_to: 1'b0, exp_init: 2};

    // Reset
    init      = 1'b1;
    run_valid = 1'b0;
    core_ack  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_core_init_during", int'(core_init), 1);
    init = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(run_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_core_init", int'(core_init), 0);
    chk("rst_core_req", int'(core_req), 0);
    chk("rst_timed_out", int'(timed_out), 0);
    chk("rst_count", int'(cycle_count), 0);
    chk("rst_runs", int'(runs_done), 0);

    // Table-driven single runs
    for (int v = 0; v < 7; v++) begin
      do_run($sformatf("vec%0d", v), vecs[v].delay, vecs[v].pre_ack,
             vecs[v].exp_count, vecs[v].exp_to, vecs[v].exp_init);
    end

    // run_valid held high: one accept every 5 cycles, none while busy
    burst(15, acc, dn);
    exp_runs = exp_runs + 8'd3;
    chk("b2b_accepts", acc, 3);
    chk("b2b_dones", dn, 3);
    chk("b2b_runs", int'(runs_done), int'(exp_runs));
    chk("b2b_idle_after", int'(run_ready), 1);

    // init pulsed mid-RUN
    run_valid = 1'b1;
    @(negedge clk);
    run_valid = 1'b0;
    w = 0;
    while (!core_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("midrst_req_seen", int'(core_req), 1);
    repeat (10) @(negedge clk);
    chk("midrst_count10", int'(cycle_count), 10);
    chk("midrst_busy", int'(busy), 1);
    init = 1'b1;
    #1;
    chk("midrst_core_init_now", int'(core_init), 1);
    @(negedge clk);
    init = 1'b0;
    #1;
    chk("midrst_ready", int'(run_ready), 1);
    chk("midrst_core_init", int'(core_init), 0);
    chk("midrst_core_req", int'(core_req), 0);
    chk("midrst_count", int'(cycle_count), 0);
    chk("midrst_runs", int'(runs_done), 0);
    chk("midrst_timed_out", int'(timed_out), 0);
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("midrst_no_done", dn, 0);
    exp_runs = 8'd0;
    do_run("post_rst", 37, 1'b0, 37, 1'b0, 2);

    // runs_done wrap: 254 more runs reach 255, one more wraps to 0
    burst(1270, acc, dn);
    chk("wrap_accepts", acc, 254);
    chk("wrap_255", int'(runs_done), 255);
    burst(5, acc, dn);
    chk("wrap_0", int'(runs_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_run_sequencer
`default_nettype wire
